// File: rtl/line_window_gen_pkg.sv
// Shared image package: frame geometry defaults, pixel width and counter sizing
// used by the line window generator and the downstream 3x3 filters.
package line_window_gen_pkg;

  localparam int DEF_COL_NUM = 1024;
  localparam int DEF_ROW_NUM = 768;
  localparam int PIX_W       = 8;

  // Counter width for a modulo-n counter; never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_COL_W = cnt_w(DEF_COL_NUM);
  localparam int DEF_ROW_W = cnt_w(DEF_ROW_NUM);

  typedef logic [PIX_W-1:0] pix_t;

  // One vertical column of the 3x3 neighbourhood, oldest line first.
  typedef struct packed {
    pix_t row1;
    pix_t row2;
    pix_t row3;
  } pix_col_t;

endpackage

// File: rtl/line_window_gen_line_ram.sv
// Simple dual-port line buffer: combinational read, synchronous write.
// Contents are deliberately not reset; the consumer gates stale data.
module line_ram
  import line_window_gen_pkg::*;
#(
  parameter int DEPTH = DEF_COL_NUM,
  parameter int WIDTH = PIX_W
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [cnt_w(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [cnt_w(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/line_window_gen.sv
// Three-row column generator: buffers the two previous lines and presents
// {line N-2, line N-1, line N} for every accepted pixel, one cycle later.
module line_window_gen
  import line_window_gen_pkg::*;
#(
  parameter int COL_NUM = DEF_COL_NUM,
  parameter int ROW_NUM = DEF_ROW_NUM
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] rx_data,
  input  logic             pi_flag,
  output logic [PIX_W-1:0] mat_row1,
  output logic [PIX_W-1:0] mat_row2,
  output logic [PIX_W-1:0] mat_row3,
  output logic             mat_flag
);

  localparam int COL_W = cnt_w(COL_NUM);
  localparam int ROW_W = cnt_w(ROW_NUM);

  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             col_last;
  logic             row_last;
  logic             row_ok;
  pix_t             a_rd;
  pix_t             b_rd;
  pix_col_t         col_q;

  assign col_last = (col_cnt == COL_W'(COL_NUM - 1));
  assign row_last = (row_cnt == ROW_W'(ROW_NUM - 1));
  // Lines 0 and 1 of a frame see the previous frame (or reset garbage) in the RAMs.
  assign row_ok   = (row_cnt >= ROW_W'(2));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (pi_flag) begin
      if (col_last) begin
        col_cnt <= '0;
        row_cnt <= row_last ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // buf_a holds line N-1; its old word shifts into buf_b (line N-2) on the same write.
  line_ram #(.DEPTH(COL_NUM), .WIDTH(PIX_W)) u_buf_a (
    .clk     (sclk),
    .wr_en   (pi_flag),
    .wr_addr (col_cnt),
    .wr_data (rx_data),
    .rd_addr (col_cnt),
    .rd_data (a_rd)
  );

  line_ram #(.DEPTH(COL_NUM), .WIDTH(PIX_W)) u_buf_b (
    .clk     (sclk),
    .wr_en   (pi_flag),
    .wr_addr (col_cnt),
    .wr_data (a_rd),
    .rd_addr (col_cnt),
    .rd_data (b_rd)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      mat_flag <= 1'b0;
    end else begin
      mat_flag <= pi_flag && row_ok;
      if (pi_flag) col_q <= '{row1: b_rd, row2: a_rd, row3: rx_data};
    end
  end

  assign mat_row1 = col_q.row1;
  assign mat_row2 = col_q.row2;
  assign mat_row3 = col_q.row3;

endmodule
